// File: rtl/pal_timing_gen_if.sv
// PAL timing bundle: the counters, strobes and sync flags
// that the generator publishes to the refclk-domain consumers.
interface pal_timing_gen_if;
  logic       running;
  logic       pix_ce;
  logic [8:0] hcnt;
  logic [8:0] vcnt;
  logic       hsync;
  logic       vsync;
  logic       active;
  logic       frame_start;

  modport master (
    output running, pix_ce, hcnt, vcnt,
    output hsync, vsync, active, frame_start
  );

  modport slave (
    input running, pix_ce, hcnt, vcnt,
    input hsync, vsync, active, frame_start
  );
endinterface

// File: rtl/pal_timing_gen.sv
// PAL video timing generator: waits for a stable PLL lock, then
// runs a 1-in-CE_DIV pixel enable and free-running h/v counters.
module pal_timing_gen #(
  parameter int CE_DIV      = 9,
  parameter int H_TOTAL     = 504,
  parameter int V_TOTAL     = 312,
  parameter int HSYNC_START = 416,
  parameter int HSYNC_LEN   = 37,
  parameter int VSYNC_START = 300,
  parameter int VSYNC_LEN   = 3,
  parameter int H_ACT_START = 24,
  parameter int H_ACT_END   = 424,
  parameter int V_ACT_START = 16,
  parameter int V_ACT_END   = 288,
  parameter int LOCK_WAIT   = 1024
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             locked,
  pal_timing_gen_if.master vid
);

  localparam int LW = $clog2(LOCK_WAIT + 1);
  localparam int CW = $clog2(CE_DIV + 1);

  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_WAIT - 1);
  localparam logic [CW-1:0] CE_LAST   = CW'(CE_DIV - 1);
  localparam logic [8:0]    H_LAST    = 9'(H_TOTAL - 1);
  localparam logic [8:0]    V_LAST    = 9'(V_TOTAL - 1);

  // Window bounds are one bit wider so an end of 512 stays exact.
  localparam logic [9:0] HS_BEG = 10'(HSYNC_START);
  localparam logic [9:0] HS_END = 10'(HSYNC_START + HSYNC_LEN);
  localparam logic [9:0] VS_BEG = 10'(VSYNC_START);
  localparam logic [9:0] VS_END = 10'(VSYNC_START + VSYNC_LEN);
  localparam logic [9:0] HA_BEG = 10'(H_ACT_START);
  localparam logic [9:0] HA_END = 10'(H_ACT_END);
  localparam logic [9:0] VA_BEG = 10'(V_ACT_START);
  localparam logic [9:0] VA_END = 10'(V_ACT_END);

  localparam bit PARAM_OK =
    (CE_DIV >= 1) && (LOCK_WAIT >= 1) &&
    (H_TOTAL >= 1) && (H_TOTAL <= 512) &&
    (V_TOTAL >= 1) && (V_TOTAL <= 512) &&
    (HSYNC_START + HSYNC_LEN <= H_TOTAL) &&
    (VSYNC_START + VSYNC_LEN <= V_TOTAL) &&
    (H_ACT_END <= H_TOTAL) && (V_ACT_END <= V_TOTAL);

  // Parameter sanity, evaluated by simulators only.
  a_params: assert property (@(posedge refclk) PARAM_OK);

  typedef enum logic {
    WAIT_LOCK,
    RUN
  } state_e;

  state_e        state_q, state_d;
  logic [LW-1:0] lock_cnt_q, lock_cnt_d;
  logic [CW-1:0] ce_cnt_q, ce_cnt_d;
  logic [8:0]    hcnt_q, hcnt_d;
  logic [8:0]    vcnt_q, vcnt_d;
  logic          running_q, running_d;
  logic          pix_ce_q, pix_ce_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          active_q, active_d;
  logic          frame_start_q, frame_start_d;
  logic [9:0]    hx, vx;

  // Next state; decodes use the next counter values so every
  // registered flag describes the counters presented with it.
  always_comb begin
    state_d       = state_q;
    lock_cnt_d    = '0;
    ce_cnt_d      = '0;
    hcnt_d        = '0;
    vcnt_d        = '0;
    running_d     = 1'b0;
    pix_ce_d      = 1'b0;
    hsync_d       = 1'b0;
    vsync_d       = 1'b0;
    active_d      = 1'b0;
    frame_start_d = 1'b0;
    hx            = '0;
    vx            = '0;

    unique case (state_q)
      WAIT_LOCK: begin
        if (locked) begin
          if (lock_cnt_q == LOCK_LAST) begin
            state_d       = RUN;
            running_d     = 1'b1;
            frame_start_d = 1'b1;
          end else begin
            lock_cnt_d = lock_cnt_q + 1'b1;
          end
        end
      end
      RUN: begin
        if (!locked) begin
          state_d = WAIT_LOCK;
        end else begin
          running_d = 1'b1;
          hcnt_d    = hcnt_q;
          vcnt_d    = vcnt_q;
          ce_cnt_d  = ce_cnt_q + 1'b1;
          if (ce_cnt_q == CE_LAST) begin
            ce_cnt_d = '0;
            pix_ce_d = 1'b1;
            if (hcnt_q == H_LAST) begin
              hcnt_d = '0;
              if (vcnt_q == V_LAST) begin
                vcnt_d = '0;
              end else begin
                vcnt_d = vcnt_q + 9'd1;
              end
            end else begin
              hcnt_d = hcnt_q + 9'd1;
            end
            frame_start_d = (hcnt_d == '0) && (vcnt_d == '0);
          end
        end
      end
    endcase

    if (running_d) begin
      hx       = {1'b0, hcnt_d};
      vx       = {1'b0, vcnt_d};
      hsync_d  = (hx >= HS_BEG) && (hx < HS_END);
      vsync_d  = (vx >= VS_BEG) && (vx < VS_END);
      active_d = (hx >= HA_BEG) && (hx < HA_END) &&
                 (vx >= VA_BEG) && (vx < VA_END);
    end
  end

  // State and output registers; rst beats every other event.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q       <= WAIT_LOCK;
      lock_cnt_q    <= '0;
      ce_cnt_q      <= '0;
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      running_q     <= 1'b0;
      pix_ce_q      <= 1'b0;
      hsync_q       <= 1'b0;
      vsync_q       <= 1'b0;
      active_q      <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      lock_cnt_q    <= lock_cnt_d;
      ce_cnt_q      <= ce_cnt_d;
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      running_q     <= running_d;
      pix_ce_q      <= pix_ce_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      active_q      <= active_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vid.running     = running_q;
  assign vid.pix_ce      = pix_ce_q;
  assign vid.hcnt        = hcnt_q;
  assign vid.vcnt        = vcnt_q;
  assign vid.hsync       = hsync_q;
  assign vid.vsync       = vsync_q;
  assign vid.active      = active_q;
  assign vid.frame_start = frame_start_q;

endmodule

// File: tb/tb_pal_timing_gen.sv
// Directed bench: full-size generator for lock and line timing,
// a scaled generator for whole-frame and mid-frame lock loss.
module tb_pal_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_b, lk_b, rst_s, lk_s;

  pal_timing_gen_if vb ();
  pal_timing_gen_if vs ();

  pal_timing_gen u_big (
    .refclk (clk),
    .rst    (rst_b),
    .locked (lk_b),
    .vid    (vb.master)
  );

  pal_timing_gen #(
    .CE_DIV      (3),
    .H_TOTAL     (20),
    .V_TOTAL     (12),
    .HSYNC_START (14),
    .HSYNC_LEN   (3),
    .VSYNC_START (9),
    .VSYNC_LEN   (2),
    .H_ACT_START (2),
    .H_ACT_END   (16),
    .V_ACT_START (1),
    .V_ACT_END   (10),
    .LOCK_WAIT   (8)
  ) u_sml (
    .refclk (clk),
    .rst    (rst_s),
    .locked (lk_s),
    .vid    (vs.master)
  );

  logic [23:0] ob, os;
  assign ob = {vb.running, vb.pix_ce, vb.hcnt, vb.vcnt,
               vb.hsync, vb.vsync, vb.active, vb.frame_start};
  assign os = {vs.running, vs.pix_ce, vs.hcnt, vs.vcnt,
               vs.hsync, vs.vsync, vs.active, vs.frame_start};

  int vecs = 0;
  int miscmp = 0;

  int n, hs, hs_first, act, dbl, prev_h, prev_v, prev_p;
  int pce, act_pce, act_cyc, hs_pce, vs_pce, vs_min, vs_max, fs;
  logic zero_ok;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miscmp++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic acc_s();
    if (vs.pix_ce) pce++;
    if (vs.active) act_cyc++;
    if (vs.pix_ce && vs.active) act_pce++;
    if (vs.pix_ce && vs.hsync) hs_pce++;
    if (vs.frame_start) fs++;
    if (vs.pix_ce && vs.vsync) begin
      vs_pce++;
      if (int'(vs.vcnt) < vs_min) vs_min = int'(vs.vcnt);
      if (int'(vs.vcnt) > vs_max) vs_max = int'(vs.vcnt);
    end
  endtask

  task automatic wait_run_b(output int cnt);
    cnt = 0;
    while (!vb.running && cnt < 1100) begin
      tick();
      cnt++;
    end
  endtask

  task automatic wait_run_s(output int cnt);
    cnt = 0;
    while (!vs.running && cnt < 40) begin
      tick();
      cnt++;
    end
  endtask

  initial begin
    rst_b = 1'b1; lk_b = 1'b1;
    rst_s = 1'b1; lk_s = 1'b0;
    repeat (4) tick();
    chk("reset_outs", 32'(ob), 0);

    rst_b = 1'b0;
    n = 0;
    zero_ok = 1'b1;
    while (!vb.running && n < 1100) begin
      tick();
      n++;
      if (!vb.running && ob != '0) zero_ok = 1'b0;
    end
    chk("lock_wait", n, 1024);
    chk("wait_outs_zero", 32'(zero_ok), 1);
    chk("entry_fs_pce_h_v",
        {vb.frame_start, vb.pix_ce, vb.hcnt, vb.vcnt},
        {1'b1, 1'b0, 9'd0, 9'd0});

    tick();
    chk("fs_one_cycle", 32'(vb.frame_start), 0);
    n = 1;
    while (!vb.pix_ce && n < 20) begin
      tick();
      n++;
    end
    chk("first_pix_ce", n, 9);
    chk("first_pix_hcnt", 32'(vb.hcnt), 1);

    n = 0;
    prev_h = 0;
    while (!(vb.pix_ce && vb.hcnt == 9'd0) && n < 5000) begin
      prev_h = int'(vb.hcnt);
      tick();
      n++;
    end
    chk("h_wrap_from", prev_h, 503);
    chk("h_wrap_vinc", 32'(vb.vcnt), 1);
    chk("h_wrap_fs", 32'(vb.frame_start), 0);

    n = 0; hs = 0; hs_first = -1; act = 0; dbl = 0;
    prev_p = 1;
    tick();
    n++;
    while (!(vb.pix_ce && vb.hcnt == 9'd0) && n < 5000) begin
      if (vb.pix_ce && prev_p != 0) dbl++;
      prev_p = int'(vb.pix_ce);
      if (vb.pix_ce && vb.hsync) begin
        hs++;
        if (hs_first < 0) hs_first = int'(vb.hcnt);
      end
      if (vb.active) act++;
      tick();
      n++;
    end
    chk("line_period", n, 4536);
    chk("line_vcnt", 32'(vb.vcnt), 2);
    chk("hsync_pixels", hs, 37);
    chk("hsync_first", hs_first, 416);
    chk("active_line1", act, 0);
    chk("pix_ce_double", dbl, 0);

    repeat (123) tick();
    rst_b = 1'b1;
    tick();
    chk("rst_midrun_outs", 32'(ob), 0);
    rst_b = 1'b0;
    wait_run_b(n);
    chk("rst_relock_wait", n, 1024);

    repeat (50) tick();
    lk_b = 1'b0;
    tick();
    chk("lockloss_big_outs", 32'(ob), 0);
    lk_b = 1'b1;
    repeat (1000) tick();
    chk("glitch_not_run", 32'(vb.running), 0);
    lk_b = 1'b0;
    tick();
    lk_b = 1'b1;
    wait_run_b(n);
    chk("glitch_relock_wait", n, 1024);

    rst_b = 1'b1;
    lk_s = 1'b1;
    repeat (2) tick();
    chk("s_reset_outs", 32'(os), 0);
    rst_s = 1'b0;
    wait_run_s(n);
    chk("s_lock_wait", n, 8);
    chk("s_entry",
        {vs.frame_start, vs.hcnt, vs.vcnt}, {1'b1, 9'd0, 9'd0});

    n = 0; prev_h = 0; prev_v = 0;
    tick();
    n++;
    while (!vs.frame_start && n < 800) begin
      prev_h = int'(vs.hcnt);
      prev_v = int'(vs.vcnt);
      tick();
      n++;
    end
    chk("s_first_frame", n, 720);
    chk("s_wrap_prev_h", prev_h, 19);
    chk("s_wrap_prev_v", prev_v, 11);
    chk("s_wrap_pce_h_v",
        {vs.pix_ce, vs.hcnt, vs.vcnt}, {1'b1, 9'd0, 9'd0});

    pce = 0; act_pce = 0; act_cyc = 0; hs_pce = 0;
    vs_pce = 0; vs_min = 999; vs_max = -1; fs = 0;
    acc_s();
    n = 1;
    tick();
    while (!vs.frame_start && n < 1500) begin
      acc_s();
      n++;
      tick();
    end
    chk("s_frame_period", n, 720);
    chk("s_frame_pix_ce", pce, 240);
    chk("s_active_pixels", act_pce, 126);
    chk("s_active_cycles", act_cyc, 378);
    chk("s_hsync_pixels", hs_pce, 36);
    chk("s_vsync_pixels", vs_pce, 40);
    chk("s_vsync_first", vs_min, 9);
    chk("s_vsync_last", vs_max, 10);
    chk("s_frame_start_cnt", fs, 1);

    n = 0;
    while (!(vs.hcnt == 9'd7 && vs.vcnt == 9'd5) && n < 800) begin
      tick();
      n++;
    end
    chk("s_reach_mid", 32'(n < 800), 1);
    lk_s = 1'b0;
    tick();
    chk("s_lockloss_outs", 32'(os), 0);
    lk_s = 1'b1;
    wait_run_s(n);
    chk("s_relock_wait", n, 8);
    chk("s_relock_entry",
        {vs.running, vs.frame_start, vs.hcnt, vs.vcnt},
        {1'b1, 1'b1, 9'd0, 9'd0});

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, miscmp);
    $finish;
  end

endmodule

// File: doc/pal_timing_gen.md
# pal_timing_gen

Video timing generator clocked by the 70.9375 MHz PLL output. Waits for a stable PLL lock, then derives a 1-in-9 pixel clock enable (7.8819 MHz PAL dot rate) and free-running horizontal/vertical counters with sync, active-area and frame-start strobes. Every downstream capture and output stage in the 70.9375 MHz domain uses it as its time base.

## Interface
- CE_DIV, 9, clock cycles per pixel enable
- H_TOTAL, 504, pixels per line
- V_TOTAL, 312, lines per frame
- HSYNC_START, 416, first hsync pixel
- HSYNC_LEN, 37, hsync width in pixels
- VSYNC_START, 300, first vsync line
- VSYNC_LEN, 3, vsync height in lines
- H_ACT_START / H_ACT_END, 24 / 424, active pixels are [start, end)
- V_ACT_START / V_ACT_END, 16 / 288, active lines are [start, end)
- LOCK_WAIT, 1024, consecutive locked cycles required before running
- refclk  in  1  70.9375 MHz clock (PLL outclk_0)
- rst  in  1  synchronous, active-high reset
- locked  in  1  PLL lock indicator, already in the refclk domain
- running  out  1  high while in RUN
- pix_ce  out  1  one-cycle pixel enable
- hcnt  out  9  pixel counter, 0..H_TOTAL-1
- vcnt  out  9  line counter, 0..V_TOTAL-1
- hsync  out  1  active-high horizontal sync
- vsync  out  1  active-high vertical sync
- active  out  1  inside the active window
- frame_start  out  1  one-cycle strobe on the first pixel of a frame

## Operation
- States: WAIT_LOCK and RUN. rst forces WAIT_LOCK.
- WAIT_LOCK:
  - lock_cnt increments while locked=1 and clears to 0 when locked=0.
  - When lock_cnt reaches LOCK_WAIT-1 with locked=1, the next state is RUN.
  - Every output holds its reset value.
- RUN:
  - ce_cnt counts 0..CE_DIV-1 and wraps. pix_ce=1 exactly when ce_cnt==CE_DIV-1.
  - On pix_ce, hcnt increments. At H_TOTAL-1 it wraps to 0 and vcnt increments.
  - vcnt wraps from V_TOTAL-1 to 0 on the same pix_ce as the hcnt wrap.
  - hsync = hcnt in [HSYNC_START, HSYNC_START+HSYNC_LEN).
  - vsync = vcnt in [VSYNC_START, VSYNC_START+VSYNC_LEN).
  - active = hcnt and vcnt both inside their active windows.
  - frame_start=1 for the single cycle in which hcnt=0 and vcnt=0 become valid.
- locked=0 in RUN: the next state is WAIT_LOCK. All counters and outputs return to reset values on the next edge. There is no partial-frame continuation.
- rst has priority over locked and over every counter event.
- Sync ranges must not wrap past the total. Parameters are checked only in simulation.
- Counter widths are fixed at 9 bits, so H_TOTAL and V_TOTAL must be ≤512.

## Timing
- Reset values: running=0, pix_ce=0, hcnt=0, vcnt=0, hsync=0, vsync=0, active=0, frame_start=0. Internal: ce_cnt=0, lock_cnt=0.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- hsync, vsync, active and frame_start update on the same edge as hcnt/vcnt, so they always describe the currently presented counter values.
- Startup:
  - locked rises at edge N. running=1 from edge N+LOCK_WAIT.
  - The first pix_ce is CE_DIV cycles later.
  - frame_start fires in the first RUN cycle, where hcnt=0 and vcnt=0.
- Line = H_TOTAL·CE_DIV = 4536 cycles. Frame = 1,415,232 cycles.
- pix_ce period is exactly CE_DIV cycles with no jitter. pix_ce is never high in two consecutive cycles when CE_DIV>1.

## Test plan
- Reset/lock wait: rst 4 cycles, locked=1. Require all outputs 0 for 1024 cycles, then running=1, and pix_ce first high 9 cycles later.
- Lock glitch: locked=1 for 1000 cycles, 0 for 1 cycle, then 1. Require running to rise 1024 cycles after the re-assertion, not earlier.
- Line timing:
  - hcnt 503→0 wrap coincides with vcnt increment; period 4536 cycles.
  - hsync high for exactly 37 pix_ce periods starting at hcnt=416.
- Frame timing:
  - vcnt 311→0 wrap; frame_start pulses once per 1,415,232 cycles.
  - vsync high for lines 300..302.
  - active high for exactly 400×272 pixel enables per frame.
- Lock loss mid-frame: drop locked at hcnt=200, vcnt=150. Next cycle require running=0 and all outputs 0. Re-lock restarts at hcnt=0, vcnt=0 with frame_start.
- rst mid-run: assert rst at arbitrary cycle with locked=1. Outputs 0 on next edge. Full LOCK_WAIT sequence repeats after release.
